// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bundle for the parallel-to-serial stage.
// The upstream producer and the serial sink use master; the serializer uses slave.
interface piso_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             serial_out;
  logic             bit_valid;
  logic             word_start;
  logic             word_end;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, serial_out, bit_valid, word_start, word_end, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, serial_out, bit_valid, word_start, word_end, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: one word per valid/ready handshake, one bit per clk,
// with start/end framing and an optional idle gap after every word.
module piso_serializer #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 0,
  parameter int MSB_FIRST  = 1
) (
  input logic   clk,
  input logic   reset,
  piso_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [7:0]    GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  if (WIDTH < 2) begin : g_bad_width
    $error("piso_serializer: WIDTH must be >= 2");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
    $error("piso_serializer: GAP_CYCLES must be in 0..255");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]       r_gap_cnt, w_gap_cnt_nxt;
  logic             r_serial, w_serial_nxt;
  logic             r_bit_valid, w_bit_valid_nxt;
  logic             r_word_start, w_word_start_nxt;
  logic             r_word_end, w_word_end_nxt;
  logic             r_busy;
  logic             w_last_bit;
  logic             w_ready;
  logic             w_accept;

  // Bit that leaves next, and the word with that bit removed.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign w_last_bit = (r_state == S_SHIFT) && (r_bit_cnt == LAST_BIT);
  assign w_ready    = !reset && ((r_state == S_IDLE) || (w_last_bit && (GAP_CYCLES == 0)));
  assign w_accept   = bus.in_valid && w_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_gap_cnt_nxt    = r_gap_cnt;
    w_serial_nxt     = 1'b0;
    w_bit_valid_nxt  = 1'b0;
    w_word_start_nxt = 1'b0;
    w_word_end_nxt   = 1'b0;
    // An accept is only possible in IDLE or on the last bit, so it always starts a fresh word.
    if (w_accept) begin
      w_state_nxt      = S_SHIFT;
      w_bit_cnt_nxt    = '0;
      w_serial_nxt     = head_bit(bus.in_data);
      w_shift_nxt      = advance(bus.in_data);
      w_bit_valid_nxt  = 1'b1;
      w_word_start_nxt = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_SHIFT: begin
          if (w_last_bit) begin
            if (GAP_CYCLES > 0) begin
              w_state_nxt   = S_GAP;
              w_gap_cnt_nxt = '0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_bit_cnt_nxt   = r_bit_cnt + 1'b1;
            w_serial_nxt    = head_bit(r_shift);
            w_shift_nxt     = advance(r_shift);
            w_bit_valid_nxt = 1'b1;
            w_word_end_nxt  = ((r_bit_cnt + 1'b1) == LAST_BIT);
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_gap_cnt_nxt = r_gap_cnt + 8'd1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_serial     <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_word_start <= 1'b0;
      r_word_end   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_serial     <= w_serial_nxt;
      r_bit_valid  <= w_bit_valid_nxt;
      r_word_start <= w_word_start_nxt;
      r_word_end   <= w_word_end_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.serial_out = r_serial;
  assign bus.bit_valid  = r_bit_valid;
  assign bus.word_start = r_word_start;
  assign bus.word_end   = r_word_end;
  assign bus.busy       = r_busy;

endmodule
